pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush scheduler for the 5-stage in-order core (IF, ID, EX, ME, WB). It generates the FORWARD_stall*/FORWARD_flush* controls consumed by every segment register, including MEM/WB.
- Resolves four hazard classes: fetch not ready, load-use, branch redirect, and multi-cycle LSU access.
- Contains a memory-wait FSM with a watchdog, and a sticky halt state.

---
 rtl/pipeline_hazard_ctrl_if.sv | 51 +++++
 rtl/pipeline_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage pipeline and the stall/flush scheduler.
// The scheduler uses the master modport. The pipeline (or a bench) uses the slave modport.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             IFU_valid;
    logic [4:0]       ID_rs1;
    logic [4:0]       ID_rs2;
    logic             ID_use_rs1;
    logic             ID_use_rs2;
    logic [4:0]       EX_rd;
    logic             EX_write_gpr;
    logic             EX_mem_to_reg;
    logic             EX_branch_taken;
    logic             MEM_req;
    logic             MEM_done;
    logic             WB_system_halt;

    logic             FORWARD_stallIF;
    logic             FORWARD_stallID;
    logic             FORWARD_stallEX;
    logic             FORWARD_stallME;
    logic             FORWARD_stallWB;
    logic             FORWARD_flushIF;
    logic             FORWARD_flushID;
    logic             FORWARD_flushEX;
    logic             FORWARD_flushME;
    logic [1:0]       ctrl_state;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        input  IFU_valid, ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2,
               EX_rd, EX_write_gpr, EX_mem_to_reg, EX_branch_taken,
               MEM_req, MEM_done, WB_system_halt,
        output FORWARD_stallIF, FORWARD_stallID, FORWARD_stallEX,
               FORWARD_stallME, FORWARD_stallWB,
               FORWARD_flushIF, FORWARD_flushID, FORWARD_flushEX, FORWARD_flushME,
               ctrl_state, mem_timeout, stall_cycles
    );

    modport slave (
        output IFU_valid, ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2,
               EX_rd, EX_write_gpr, EX_mem_to_reg, EX_branch_taken,
               MEM_req, MEM_done, WB_system_halt,
        input  FORWARD_stallIF, FORWARD_stallID, FORWARD_stallEX,
               FORWARD_stallME, FORWARD_stallWB,
               FORWARD_flushIF, FORWARD_flushID, FORWARD_flushEX, FORWARD_flushME,
               ctrl_state, mem_timeout, stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the IF-ID-EX-ME-WB core: load-use, branch redirect,
// fetch starvation, and multi-cycle LSU wait with a watchdog and a sticky halt.
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_e;

    localparam int WAIT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    // Stall bits are {IF, ID, EX, ME, WB}. Flush bits are {IF, ID, EX, ME}.
    localparam logic [4:0] STALL_NONE = 5'b00000;
    localparam logic [4:0] STALL_ALL  = 5'b11111;
    localparam logic [4:0] STALL_MEM  = 5'b11110;
    localparam logic [4:0] STALL_LU   = 5'b11000;
    localparam logic [4:0] STALL_IF   = 5'b10000;
    localparam logic [3:0] FLUSH_NONE = 4'b0000;
    localparam logic [3:0] FLUSH_ALL  = 4'b1111;
    localparam logic [3:0] FLUSH_MEM  = 4'b0001;
    localparam logic [3:0] FLUSH_BR   = 4'b1100;
    localparam logic [3:0] FLUSH_LU   = 4'b0100;
    localparam logic [3:0] FLUSH_IF   = 4'b1000;

    state_e            state;
    state_e            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_q;
    logic [CNT_W-1:0]  stall_cnt;
    logic [4:0]        stall;
    logic [3:0]        flush;
    logic              load_use;
    logic              mem_miss;
    logic              wait_expired;

    assign load_use = bus.EX_mem_to_reg & bus.EX_write_gpr & (bus.EX_rd != 5'd0) &
                      ((bus.ID_use_rs1 & (bus.ID_rs1 == bus.EX_rd)) |
                       (bus.ID_use_rs2 & (bus.ID_rs2 == bus.EX_rd)));
    assign mem_miss     = bus.MEM_req & ~bus.MEM_done;
    assign wait_expired = (wait_cnt == WAIT_W'(TIMEOUT));

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= state_nxt;
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path infers a latch.
        state_nxt = state;
        case (state)
            RUN: begin
                if (bus.WB_system_halt) state_nxt = HALT;
                else if (mem_miss)      state_nxt = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (bus.MEM_done)       state_nxt = RUN;
                else if (wait_expired)  state_nxt = HALT;
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = RUN;
        endcase
    end

    // The branch is not examined in MEM_WAIT. EX holds it, so it is redirected after the return to RUN.
    always_comb begin
        stall = STALL_NONE;
        flush = FLUSH_NONE;
        if (!rst) begin
            flush = FLUSH_ALL;
        end else begin
            case (state)
                RUN: begin
                    if (bus.WB_system_halt) begin
                        stall = STALL_ALL;
                    end else if (mem_miss) begin
                        stall = STALL_MEM;
                        flush = FLUSH_MEM;
                    end else if (bus.EX_branch_taken) begin
                        flush = FLUSH_BR;
                    end else if (load_use) begin
                        stall = STALL_LU;
                        flush = FLUSH_LU;
                    end else if (!bus.IFU_valid) begin
                        stall = STALL_IF;
                        flush = FLUSH_IF;
                    end
                end
                MEM_WAIT: begin
                    if (!bus.MEM_done) begin
                        stall = STALL_MEM;
                        flush = FLUSH_MEM;
                    end
                end
                HALT:    stall = STALL_ALL;
                default: stall = STALL_NONE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (state == RUN && state_nxt == MEM_WAIT)
                wait_cnt <= WAIT_W'(1);
            else if (state == MEM_WAIT && state_nxt == MEM_WAIT)
                wait_cnt <= wait_cnt + WAIT_W'(1);

            if (state == MEM_WAIT && state_nxt == HALT)
                timeout_q <= 1'b1;

            if (stall[4] && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign {bus.FORWARD_stallIF, bus.FORWARD_stallID, bus.FORWARD_stallEX,
            bus.FORWARD_stallME, bus.FORWARD_stallWB} = stall;
    assign {bus.FORWARD_flushIF, bus.FORWARD_flushID, bus.FORWARD_flushEX,
            bus.FORWARD_flushME} = flush;
    assign bus.ctrl_state   = state;
    assign bus.mem_timeout  = timeout_q;
    assign bus.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl (TIMEOUT = 4).
// Stimulus pushes expected outputs, and a negedge monitor pops them and compares.
module tb_pipeline_hazard_ctrl;

    localparam logic [4:0] S0   = 5'b00000;
    localparam logic [4:0] SALL = 5'b11111;
    localparam logic [4:0] SMEM = 5'b11110;
    localparam logic [4:0] SLU  = 5'b11000;
    localparam logic [4:0] SIF  = 5'b10000;
    localparam logic [3:0] F0   = 4'b0000;
    localparam logic [3:0] FRST = 4'b1111;
    localparam logic [3:0] FMEM = 4'b0001;
    localparam logic [3:0] FBR  = 4'b1100;
    localparam logic [3:0] FLU  = 4'b0100;
    localparam logic [3:0] FIF  = 4'b1000;

    typedef struct {
        string       name;
        logic [4:0]  stall;
        logic [3:0]  flush;
        logic [1:0]  state;
        logic        tmo;
        logic [31:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    pipeline_hazard_ctrl_if #(.CNT_W(32)) bus ();

    pipeline_hazard_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input string name, input logic [4:0] es, input logic [3:0] ef,
                            input logic [1:0] est, input logic etmo, input logic [31:0] ecnt);
        exp_t e;
        e.name = name; e.stall = es; e.flush = ef; e.state = est; e.tmo = etmo; e.cnt = ecnt;
        sb_q.push_back(e);
    endtask

    // Argument order: ifu rs1 rs2 use1 use2 rd wr ld br req done halt | stall flush state tmo cnt
    task automatic step(input string name,
                        input logic ifu, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic wr, input logic ld, input logic br,
                        input logic req, input logic done, input logic halt,
                        input logic [4:0] es, input logic [3:0] ef, input logic [1:0] est,
                        input logic etmo, input logic [31:0] ecnt);
        bus.IFU_valid = ifu;  bus.ID_rs1 = rs1;      bus.ID_rs2 = rs2;
        bus.ID_use_rs1 = u1;  bus.ID_use_rs2 = u2;   bus.EX_rd = rd;
        bus.EX_write_gpr = wr; bus.EX_mem_to_reg = ld; bus.EX_branch_taken = br;
        bus.MEM_req = req;    bus.MEM_done = done;   bus.WB_system_halt = halt;
        push_exp(name, es, ef, est, etmo, ecnt);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // Reset is dropped between clock edges and checked before the next edge.
    task automatic async_rst(input string name);
        #2;
        rst = 1'b0;
        push_exp(name, S0, FRST, 2'd0, 1'b0, 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        logic [4:0] got_s;
        logic [3:0] got_f;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                got_s = {bus.FORWARD_stallIF, bus.FORWARD_stallID, bus.FORWARD_stallEX,
                         bus.FORWARD_stallME, bus.FORWARD_stallWB};
                got_f = {bus.FORWARD_flushIF, bus.FORWARD_flushID, bus.FORWARD_flushEX,
                         bus.FORWARD_flushME};
                n_checks++;
                if (got_s === e.stall && got_f === e.flush && bus.ctrl_state === e.state &&
                    bus.mem_timeout === e.tmo && bus.stall_cycles === e.cnt)
                    n_pass++;
                else
                    $display("FAIL %s: got stall=%b flush=%b state=%0d tmo=%b cnt=%0d, expected stall=%b flush=%b state=%0d tmo=%b cnt=%0d",
                             e.name, got_s, got_f, bus.ctrl_state, bus.mem_timeout, bus.stall_cycles,
                             e.stall, e.flush, e.state, e.tmo, e.cnt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        //    name                   ifu rs1   rs2   u1 u2 rd    wr ld br rq dn ht  stall flush st tmo cnt
        step("reset_hold",           1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, S0,   FRST, 0, 0, 0);
        rst = 1'b1;
        step("idle",                 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, S0,   F0,   0, 0, 0);
        step("lu_rs2",               1, 5'd3, 5'd5, 1, 1, 5'd5, 1, 1, 0, 0, 0, 0, SLU,  FLU,  0, 0, 0);
        step("lu_release",           1, 5'd3, 5'd5, 1, 1, 5'd0, 0, 0, 0, 0, 0, 0, S0,   F0,   0, 0, 1);
        step("lu_rs1",               1, 5'd7, 5'd2, 1, 0, 5'd7, 1, 1, 0, 0, 0, 0, SLU,  FLU,  0, 0, 1);
        step("lu_x0",                1, 5'd0, 5'd0, 1, 1, 5'd0, 1, 1, 0, 0, 0, 0, S0,   F0,   0, 0, 2);
        step("lu_rs2_unused",        1, 5'd4, 5'd9, 1, 0, 5'd9, 1, 1, 0, 0, 0, 0, S0,   F0,   0, 0, 2);
        step("alu_no_lu",            1, 5'd9, 5'd9, 1, 1, 5'd9, 1, 0, 0, 0, 0, 0, S0,   F0,   0, 0, 2);
        step("fetch_stall",          0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, SIF,  FIF,  0, 0, 2);
        step("branch_beats_fetch",   0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0, 0, S0,   FBR,  0, 0, 3);
        step("branch_beats_lu",      1, 5'd5, 5'd5, 1, 1, 5'd5, 1, 1, 1, 0, 0, 0, S0,   FBR,  0, 0, 3);
        step("idle2",                1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, S0,   F0,   0, 0, 3);
        step("mem_req",              1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, 0, SMEM, FMEM, 0, 0, 3);
        step("mem_wait1",            0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, 0, SMEM, FMEM, 1, 0, 4);
        step("mem_wait2",            1, 5'd5, 5'd5, 1, 1, 5'd5, 1, 1, 0, 1, 0, 0, SMEM, FMEM, 1, 0, 5);
        step("mem_done",             1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 1, 0, S0,   F0,   1, 0, 6);
        step("mem_after",            1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, S0,   F0,   0, 0, 6);
        step("mem_single",           1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 1, 0, S0,   F0,   0, 0, 6);
        step("mem_single_fetch",     0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 1, 0, SIF,  FIF,  0, 0, 6);
        step("mem_single_branch",    1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 1, 0, S0,   FBR,  0, 0, 7);
        step("bw_req",               1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 0, 0, SMEM, FMEM, 0, 0, 7);
        step("bw_wait",              1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 0, 0, SMEM, FMEM, 1, 0, 8);
        step("bw_done",              1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 1, 0, S0,   F0,   1, 0, 9);
        step("bw_redirect",          1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0, 0, S0,   FBR,  0, 0, 9);
        step("idle3",                1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, S0,   F0,   0, 0, 9);
        step("wd_req",               1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, 0, SMEM, FMEM, 0, 0, 9);
        step("wd_wait1",             1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, 0, SMEM, FMEM, 1, 0, 10);
        step("wd_wait2",             1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, 0, SMEM, FMEM, 1, 0, 11);
        step("wd_wait3",             1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, 0, SMEM, FMEM, 1, 0, 12);
        step("wd_wait4",             1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, 0, SMEM, FMEM, 1, 0, 13);
        step("wd_halt",              1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, 0, SALL, F0,   2, 1, 14);
        step("wd_halt_toggle",       0, 5'd5, 5'd5, 1, 1, 5'd5, 1, 1, 1, 1, 1, 1, SALL, F0,   2, 1, 15);
        async_rst("rst_in_wd_halt");
        step("rst_held",             1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, S0,   FRST, 0, 0, 0);
        rst = 1'b1;
        step("idle4",                1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, S0,   F0,   0, 0, 0);
        step("halt_priority",        0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 0, 1, SALL, F0,   0, 0, 0);
        step("halt_sticky1",         1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, SALL, F0,   2, 0, 1);
        step("halt_sticky2",         0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 1, 0, SALL, F0,   2, 0, 2);
        step("halt_sticky3",         1, 5'd6, 5'd6, 1, 1, 5'd6, 1, 1, 0, 1, 0, 0, SALL, F0,   2, 0, 3);
        async_rst("rst_in_halt");
        rst = 1'b1;
        step("idle_final",           1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, S0,   F0,   0, 0, 0);

        for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
